// File: rtl/csa_accumulator.sv
// Packet accumulator: carry-save compression per beat, then a chunked ripple resolve.
// Optional signed-overflow detection with 8 guard bits is enabled by defining CFG_OVF_EN.
module csa_accumulator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_of
);

    localparam int K = WIDTH / CHUNK;
`ifdef CFG_OVF_EN
    localparam int GW    = 8;
    localparam int NSTEP = K + 1;
`else
    localparam int GW    = 0;
    localparam int NSTEP = K;
`endif
    localparam int SW = WIDTH + GW;
    localparam int CW = $clog2(NSTEP + 1);

    localparam logic [1:0] ST_ACCUM   = 2'd0;
    localparam logic [1:0] ST_RESOLVE = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    logic [1:0]       r_state;
    logic [SW-1:0]    r_s;
    logic [SW-1:0]    r_c;
    logic             r_wrap;
    logic             r_rc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_of;

    logic [SW-1:0]    w_in_ext;
    logic [SW-1:0]    w_s_csa;
    logic [SW-1:0]    w_maj;
    logic [CHUNK:0]   w_chunk;
    logic [WIDTH-1:0] w_sum_shift;
    logic             w_last_low;

`ifdef CFG_OVF_EN
    assign w_in_ext = {{GW{in_data[WIDTH-1]}}, in_data};
`else
    assign w_in_ext = in_data;
`endif

    // One full-adder cell per bit: sum stays in place, majority becomes the carry.
    genvar gi;
    generate
        for (gi = 0; gi < SW; gi++) begin : g_csa
            assign w_s_csa[gi] = r_s[gi] ^ r_c[gi] ^ w_in_ext[gi];
            assign w_maj[gi]   = (r_s[gi] & r_c[gi]) |
                                 (r_s[gi] & w_in_ext[gi]) |
                                 (r_c[gi] & w_in_ext[gi]);
        end
    endgenerate

    // S and C are shifted down each resolve step, so the active chunk is always at the bottom.
    assign w_chunk     = {1'b0, r_s[CHUNK-1:0]} + {1'b0, r_c[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_rc};
    assign w_sum_shift = (r_sum >> CHUNK) | (WIDTH'(w_chunk[CHUNK-1:0]) << (WIDTH - CHUNK));
    assign w_last_low  = (r_cnt == CW'(K - 1));

`ifdef CFG_OVF_EN
    logic [GW-1:0] w_guard;
    assign w_guard = r_s[GW-1:0] + r_c[GW-1:0] + {{(GW-1){1'b0}}, r_rc};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_s     <= '0;
            r_c     <= '0;
            r_wrap  <= 1'b0;
            r_rc    <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_of    <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_s    <= w_s_csa;
                        r_c    <= w_maj << 1;
                        // Carry out of bit WIDTH-1 is the unsigned wrap in both builds.
                        r_wrap <= r_wrap | w_maj[WIDTH-1];
                        if (in_last) begin
                            r_state <= ST_RESOLVE;
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_RESOLVE: begin
                    if (r_cnt != CW'(K)) begin
                        r_sum <= w_sum_shift;
                        r_rc  <= w_chunk[CHUNK];
                        r_s   <= r_s >> CHUNK;
                        r_c   <= r_c >> CHUNK;
                        if (w_last_low) begin
                            r_carry <= r_wrap | w_chunk[CHUNK];
                        end
                    end
`ifdef CFG_OVF_EN
                    else begin
                        r_of <= (w_guard != {GW{r_sum[WIDTH-1]}});
                    end
`endif
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(NSTEP - 1)) begin
                        r_state <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_wrap  <= 1'b0;
                        r_rc    <= 1'b0;
                        r_state <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_OUTPUT);
    assign out_sum   = r_sum;
    assign out_carry = r_carry;
    assign out_of    = r_of;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator at default parameters; expectations follow CFG_OVF_EN.
module tb_csa_accumulator;

`ifdef CFG_OVF_EN
    localparam int          LAT    = 5;
    localparam logic [31:0] OF_EXP = 32'd1;
`else
    localparam int          LAT    = 4;
    localparam logic [31:0] OF_EXP = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        out_of;

    int n_checks = 0;
    int n_fail   = 0;
    bit junk     = 1'b0;

    csa_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_of    (out_of)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] data, input logic last);
        check_value("beat_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        tick();
        // After a last beat, optionally keep junk on the input to prove it is ignored.
        in_valid = junk & last;
        in_last  = junk & last;
        in_data  = 32'hDEADBEEF;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_out(input string tag, input logic [31:0] exp_sum,
                            input logic exp_carry, input logic [31:0] exp_of);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_value({tag, "_lat"}, lat, LAT);
        check_value({tag, "_sum"}, out_sum, exp_sum);
        check_value({tag, "_carry"}, {31'b0, out_carry}, {31'b0, exp_carry});
        check_value({tag, "_of"}, {31'b0, out_of}, exp_of);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_value({tag, "_vld_clr"}, {31'b0, out_valid}, 32'd0);
        check_value({tag, "_rdy_set"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        idle(3);
        check_value("rst_ready", {31'b0, in_ready}, 32'd1);
        check_value("rst_valid", {31'b0, out_valid}, 32'd0);
        check_value("rst_sum", out_sum, 32'd0);
        check_value("rst_carry", {31'b0, out_carry}, 32'd0);
        check_value("rst_of", {31'b0, out_of}, 32'd0);
        rst = 1'b0;
        tick();

        // Single beat, with junk beats driven while busy.
        junk = 1'b1;
        send(32'h00000005, 1'b1);
        wait_out("single", 32'h00000005, 1'b0, 32'd0);
        handshake("single");
        junk = 1'b0;

        send(32'hFFFFFFFF, 1'b0);
        send(32'h00000001, 1'b0);
        send(32'h00000001, 1'b1);
        wait_out("wrap", 32'h00000001, 1'b1, 32'd0);
        handshake("wrap");

        send(32'h7FFFFFFF, 1'b0);
        send(32'h00000001, 1'b1);
        wait_out("sovf", 32'h80000000, 1'b0, OF_EXP);
        handshake("sovf");

        // Backpressure: result must hold for 10 cycles.
        send(32'h12345678, 1'b0);
        send(32'h11111111, 1'b1);
        wait_out("stall", 32'h23456789, 1'b0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_value("stall_vld", {31'b0, out_valid}, 32'd1);
            check_value("stall_sum", out_sum, 32'h23456789);
            check_value("stall_rdy", {31'b0, in_ready}, 32'd0);
        end
        handshake("stall");
        send(32'h80000000, 1'b0);
        send(32'h80000000, 1'b1);
        wait_out("negovf", 32'h00000000, 1'b1, OF_EXP);
        handshake("negovf");

        // Reset in the middle of resolve.
        send(32'h00000100, 1'b0);
        send(32'h00000200, 1'b1);
        idle(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("abort_vld", {31'b0, out_valid}, 32'd0);
        check_value("abort_rdy", {31'b0, in_ready}, 32'd1);
        idle(6);
        check_value("abort_quiet", {31'b0, out_valid}, 32'd0);
        send(32'h00000002, 1'b0);
        send(32'h00000003, 1'b1);
        wait_out("after_rst", 32'h00000005, 1'b0, 32'd0);
        handshake("after_rst");

        // Reset in the middle of accumulation.
        send(32'h00000001, 1'b0);
        send(32'h00000002, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(32'h00000007, 1'b1);
        wait_out("acc_rst", 32'h00000007, 1'b0, 32'd0);
        handshake("acc_rst");

        send(32'd10, 1'b0);
        idle(3);
        send(32'd20, 1'b0);
        idle(3);
        send(32'd30, 1'b1);
        wait_out("gaps", 32'h0000003C, 1'b0, 32'd0);
        handshake("gaps");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
